// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel frame controller.
package neopixel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        LATCH
    } state_e;

    // Colour word layout: r[23:16], g[15:8], b[7:0]
    localparam int R_MSB = 23;
    localparam int G_MSB = 15;
    localparam int B_MSB = 7;

    localparam int DEFAULT_CLK_HZ = 12_000_000;

endpackage

// File: rtl/neopixel_frame_ram.sv
// Frame buffer: one write port, one registered read port (1-cycle latency).
// Read-during-write to the same address returns the old word.
module neopixel_frame_ram
    import neopixel_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [R_MSB:0]    wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [R_MSB:0]    rd_data
);

    // Sized to the full address space so every index is in range; only
    // the first DEPTH entries are ever written.
    logic [R_MSB:0] mem [2**ADDR_W];
    logic [R_MSB:0] rd_data_q, rd_data_d;
    logic           wr_ok;

    // Drop out-of-range writes; hold the read register unless a read is issued
    always_comb begin
        wr_ok     = wr_en && (32'(wr_addr) < DEPTH);
        rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
    end

    // Storage and read register (no reset so the array maps to block RAM)
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/neopixel_strip_ctrl.sv
// Frame sequencer: streams the frame buffer pixel-by-pixel into the serial
// writer over valid/busy, retries unacknowledged loads, then holds the strip
// latch gap before reporting frame_done.
module neopixel_strip_ctrl
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS   = 8,
    parameter int ADDR_W       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
    parameter int LATCH_CYCLES = 960,   // must be >= 2
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              start,
    input  logic              auto_refresh,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              ack_err,
    output logic              pix_valid,
    output logic [7:0]        pix_r,
    output logic [7:0]        pix_g,
    output logic [7:0]        pix_b,
    input  logic              pix_busy
);

    localparam int CNT_MAX = (LATCH_CYCLES > ACK_TIMEOUT) ? LATCH_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              pix_valid_q, pix_valid_d;
    logic              frame_busy_q, frame_busy_d;
    logic              frame_done_q, frame_done_d;
    logic              ack_err_q, ack_err_d;
    logic [1:0]        rst_sync_q, rst_sync_d;
    logic              rst_int_n;
    logic              rd_en;
    logic [23:0]       rd_data;
    logic              last_pix;

    neopixel_frame_ram #(
        .DEPTH  (NUM_PIXELS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    // Reset release is resynchronised to clk; assertion still acts at once
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Reset synchroniser register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];
    assign last_pix  = (idx_q == ADDR_W'(NUM_PIXELS - 1));

    // Next-state logic; pix_valid/frame_done are decoded one cycle early so
    // they come straight from flops
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rgb_d        = rgb_q;
        pix_valid_d  = 1'b0;
        frame_busy_d = frame_busy_q;
        frame_done_d = 1'b0;
        ack_err_d    = ack_err_q;
        rd_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || auto_refresh) begin
                    state_d      = FETCH;
                    idx_d        = '0;
                    frame_busy_d = 1'b1;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                rgb_d = rd_data;
                if (!pix_busy) begin
                    state_d     = ISSUE;
                    pix_valid_d = 1'b1;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (pix_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    ack_err_d   = 1'b1;
                    state_d     = ISSUE;
                    pix_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!pix_busy) begin
                    if (last_pix) begin
                        // The cycle that saw busy fall is the first idle
                        // cycle of the latch gap, so the count starts at 1
                        state_d = LATCH;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            LATCH: begin
                if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
                    frame_done_d = 1'b1;
                    if (auto_refresh) begin
                        state_d = FETCH;
                        idx_d   = '0;
                    end else begin
                        state_d      = IDLE;
                        frame_busy_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and output registers
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            rgb_q        <= '0;
            pix_valid_q  <= 1'b0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rgb_q        <= rgb_d;
            pix_valid_q  <= pix_valid_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;
    assign ack_err    = ack_err_q;
    assign pix_r      = rgb_q[R_MSB -: 8];
    assign pix_g      = rgb_q[G_MSB -: 8];
    assign pix_b      = rgb_q[B_MSB -: 8];

endmodule
